// File: rtl/mc_datapath_p.sv
// Parametrised multicycle MIPS-subset datapath with internal ALU, bus-stall gating
// and overflow exception capture (EPC/Cause).
module mc_datapath_p #(
  parameter int          XLEN       = 32,
  parameter int          NREG       = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MIO_ready,
  input  logic            IorD,
  input  logic            IRWrite,
  input  logic [1:0]      RegDst,
  input  logic            RegWrite,
  input  logic [1:0]      MemtoReg,
  input  logic            ALUSrcA,
  input  logic [1:0]      ALUSrcB,
  input  logic            ExtZero,
  input  logic [1:0]      PCSource,
  input  logic            PCWrite,
  input  logic            PCWriteCond,
  input  logic            Branch,
  input  logic            ExcEn,
  input  logic [3:0]      ALU_operation,
  input  logic [XLEN-1:0] data2CPU,
  output logic [XLEN-1:0] PC_Current,
  output logic [31:0]     Inst,
  output logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] M_addr,
  output logic            zero,
  output logic            overflow,
  output logic [XLEN-1:0] EPC,
  output logic [4:0]      Cause,
  output logic            exc_pend
);

  localparam int AW = $clog2(NREG);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_XOR = 4'b0011,
    ALU_SLL = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_op_e;

  logic [XLEN-1:0] pc_q, pc_d, mdr_q, mdr_d, aluout_q, aluout_d, epc_q, epc_d;
  logic [31:0]     ir_q, ir_d;
  logic [4:0]      cause_q, cause_d;
  logic            exc_pend_q, exc_pend_d;
  logic [XLEN-1:0] regs_q [NREG];

  logic            adv, exc, pc_we, rf_we;
  logic [4:0]      rs_a, rt_a, wa;
  logic [XLEN-1:0] rs_data, rt_data, wd, pc_next;
  logic [XLEN-1:0] imm_ext, alu_a, alu_b, alu_res, sum, diff;
  logic [4:0]      shamt;
  alu_op_e         alu_op;

  assign adv   = MIO_ready & ~reset;
  assign rs_a  = ir_q[25:21];
  assign rt_a  = ir_q[20:16];
  assign shamt = ir_q[10:6];

  // Register file read: r0 and addresses beyond the implemented depth read as zero.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs_a != 5'd0 && int'(rs_a) < NREG) rs_data = regs_q[rs_a[AW-1:0]];
    if (rt_a != 5'd0 && int'(rt_a) < NREG) rt_data = regs_q[rt_a[AW-1:0]];
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    wa = 5'd0;
    case (RegDst)
      2'd0:    wa = ir_q[20:16];
      2'd1:    wa = ir_q[15:11];
      2'd2:    wa = 5'd31;
      default: wa = 5'd0;
    endcase
    wd = aluout_q;
    case (MemtoReg)
      2'd0:    wd = aluout_q;
      2'd1:    wd = mdr_q;
      2'd2:    wd = XLEN'($signed({ir_q[15:0], 16'h0000}));
      default: wd = pc_q;
    endcase
  end

  assign rf_we = adv & RegWrite & ~exc_pend_q & (RegDst != 2'd3) &
                 (wa != 5'd0) & (int'(wa) < NREG);

  assign imm_ext = ExtZero ? XLEN'(ir_q[15:0]) : XLEN'($signed(ir_q[15:0]));
  assign alu_a   = ALUSrcA ? rs_data : pc_q;

  always_comb begin
    alu_b = rt_data;
    case (ALUSrcB)
      2'd0:    alu_b = rt_data;
      2'd1:    alu_b = XLEN'(4);
      2'd2:    alu_b = imm_ext;
      default: alu_b = imm_ext << 2;
    endcase
  end

  assign sum    = alu_a + alu_b;
  assign diff   = alu_a - alu_b;
  assign alu_op = alu_op_e'(ALU_operation);

  always_comb begin
    alu_res  = '0;
    overflow = 1'b0;
    case (alu_op)
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_XOR: alu_res = alu_a ^ alu_b;
      ALU_NOR: alu_res = ~(alu_a | alu_b);
      ALU_ADD: begin
        alu_res  = sum;
        overflow = (alu_a[XLEN-1] == alu_b[XLEN-1]) && (sum[XLEN-1] != alu_a[XLEN-1]);
      end
      ALU_SUB: begin
        alu_res  = diff;
        overflow = (alu_a[XLEN-1] != alu_b[XLEN-1]) && (diff[XLEN-1] != alu_a[XLEN-1]);
      end
      ALU_SLT: alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SRL: alu_res = alu_b >> shamt;
      ALU_SLL: alu_res = alu_b << shamt;
      default: alu_res = '0;
    endcase
  end

  assign zero = (alu_res == '0);

  always_comb begin
    pc_next = alu_res;
    case (PCSource)
      2'd0:    pc_next = alu_res;
      2'd1:    pc_next = aluout_q;
      2'd2:    pc_next = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
      default: pc_next = epc_q;
    endcase
  end

  assign pc_we = (PCWrite | (PCWriteCond & (Branch ~^ zero))) & adv;
  assign exc   = adv & ExcEn & overflow;

  // Next-state: hold by default; an exception overrides any PC write and pending clear.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    mdr_d      = mdr_q;
    aluout_d   = aluout_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    exc_pend_d = exc_pend_q;
    if (adv) begin
      mdr_d    = data2CPU;
      aluout_d = alu_res;
      if (IRWrite) ir_d = data2CPU[31:0];
      if (exc) begin
        pc_d       = XLEN'(EXC_VECTOR);
        epc_d      = pc_q - XLEN'(4);
        cause_d    = 5'd12;
        exc_pend_d = 1'b1;
      end else begin
        if (pc_we)   pc_d       = pc_next;
        if (IRWrite) exc_pend_d = 1'b0;
      end
    end
  end

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= XLEN'(RESET_PC);
      ir_q       <= '0;
      mdr_q      <= '0;
      aluout_q   <= '0;
      epc_q      <= '0;
      cause_q    <= '0;
      exc_pend_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      mdr_q      <= mdr_d;
      aluout_q   <= aluout_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      exc_pend_q <= exc_pend_d;
    end
  end

  // NOTE: the register file is reset in full, so it maps to flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[wa[AW-1:0]] <= wd;
    end
  end

  assign PC_Current = pc_q;
  assign Inst       = ir_q;
  assign data_out   = rt_data;
  assign M_addr     = IorD ? aluout_q : pc_q;
  assign EPC        = epc_q;
  assign Cause      = cause_q;
  assign exc_pend   = exc_pend_q;

endmodule
